// File: rtl/mips_defs_pkg.sv
// mips_defs_pkg: opcodes, instruction field positions and decode FSM states
package mips_defs_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_HALT  = 6'b111111;
  localparam int OPC_LSB = 26;
  localparam int RS_LSB  = 21;
  localparam int RT_LSB  = 16;
  localparam int RD_LSB  = 11;
  localparam int SH_LSB  = 6;
  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;
endpackage

// File: rtl/decode_hazard_block_hazard_detect.sv
// hazard_detect: combinational lw load-use comparator
// ld_q/ld_rt_q: previous bundle was lw and its rt; ins: current instruction; hazard: refetch needed
module hazard_detect
  import mips_defs_pkg::*;
#(
  parameter int INS_W = 32
) (
  input  logic             ld_q,
  input  logic [4:0]       ld_rt_q,
  input  logic [INS_W-1:0] ins,
  output logic             hazard
);
  logic [5:0] op;
  logic       no_src;
  logic       uses_rt;
  always_comb begin
    op      = ins[OPC_LSB +: 6];
    no_src  = op == OP_J || op == OP_JAL || op == OP_HALT || ins == '0;
    uses_rt = op == OP_RTYPE || op == OP_SW || op == OP_BEQ || op == OP_BNE;
    hazard  = ld_q && ld_rt_q != '0 && !no_src &&
              (ld_rt_q == ins[RS_LSB +: 5] || (uses_rt && ld_rt_q == ins[RT_LSB +: 5]));
  end
endmodule

// File: rtl/decode_hazard_block.sv
// decode_hazard_block: registers fetched instruction fields, stalls on lw load-use, resolves J/JAL, freezes on HALT
// in: clk, reset (sync, active-low), ins (for address of previous cycle), current_address
// out to fetch: stall, stall_pm, pc_mux_sel, jmp_loc; out to execute: id_* bundle; halted
module decode_hazard_block
  import mips_defs_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int INS_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [INS_W-1:0]  ins,
  input  logic [ADDR_W-1:0] current_address,
  output logic              stall,
  output logic              stall_pm,
  output logic              pc_mux_sel,
  output logic [ADDR_W-1:0] jmp_loc,
  output logic              id_valid,
  output logic [5:0]        id_opcode,
  output logic [4:0]        id_rs,
  output logic [4:0]        id_rt,
  output logic [4:0]        id_rd,
  output logic [4:0]        id_shamt,
  output logic [5:0]        id_funct,
  output logic [31:0]       id_imm,
  output logic [ADDR_W-1:0] id_pc,
  output logic              halted
);
  state_t            state;
  logic [ADDR_W-1:0] pc_q;
  logic              ld_q;
  logic [4:0]        ld_rt_q;
  logic              hazard;
  logic [5:0]        op;
  logic              is_halt;
  logic              is_j;
  hazard_detect #(.INS_W(INS_W)) u_hazard (
    .ld_q    (ld_q),
    .ld_rt_q (ld_rt_q),
    .ins     (ins),
    .hazard  (hazard)
  );
  always_comb begin
    op         = ins[OPC_LSB +: 6];
    is_halt    = op == OP_HALT;
    is_j       = op == OP_J || op == OP_JAL;
    stall      = reset && (state == HALT || is_halt || hazard);
    stall_pm   = reset && state == HALT;
    pc_mux_sel = reset && state == RUN && is_j && !hazard;
    jmp_loc    = pc_mux_sel ? ins[ADDR_W-1:0] : '0;
    halted     = state == HALT;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= RUN;
      pc_q      <= '0;
      ld_q      <= 1'b0;
      ld_rt_q   <= '0;
      id_valid  <= 1'b0;
      id_opcode <= '0;
      id_rs     <= '0;
      id_rt     <= '0;
      id_rd     <= '0;
      id_shamt  <= '0;
      id_funct  <= '0;
      id_imm    <= '0;
      id_pc     <= '0;
    end else begin
      pc_q     <= current_address;
      id_valid <= 1'b0;
      ld_q     <= 1'b0;
      if (state == RUN && is_halt) state <= HALT;
      else if (state == RUN && !hazard) begin
        id_valid  <= 1'b1;
        id_opcode <= op;
        id_rs     <= ins[RS_LSB +: 5];
        id_rt     <= ins[RT_LSB +: 5];
        id_rd     <= ins[RD_LSB +: 5];
        id_shamt  <= ins[SH_LSB +: 5];
        id_funct  <= ins[5:0];
        id_imm    <= {{16{ins[15]}}, ins[15:0]};
        id_pc     <= pc_q;
        ld_q      <= op == OP_LW;
        ld_rt_q   <= ins[RT_LSB +: 5];
      end
    end
  end
endmodule

// File: tb/tb_decode_hazard_block.sv
// tb_decode_hazard_block: directed vectors checked against a rule-level model every cycle plus literal spot checks
module tb_decode_hazard_block;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] ins = 32'hFFFFFFFF;
  logic [15:0] current_address = '0;
  logic        stall, stall_pm, pc_mux_sel, id_valid, halted;
  logic [15:0] jmp_loc, id_pc;
  logic [5:0]  id_opcode, id_funct;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
  logic [31:0] id_imm;
  int cmp_n = 0;
  int err_n = 0;
  always #5 clk = ~clk;
  decode_hazard_block dut (
    .clk(clk), .reset(reset), .ins(ins), .current_address(current_address),
    .stall(stall), .stall_pm(stall_pm), .pc_mux_sel(pc_mux_sel), .jmp_loc(jmp_loc),
    .id_valid(id_valid), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_shamt(id_shamt), .id_funct(id_funct), .id_imm(id_imm),
    .id_pc(id_pc), .halted(halted)
  );
  // model state: what decode has committed, in instruction terms
  bit          m_init = 0;
  bit          m_valid = 0;
  bit          m_halted = 0;
  bit          m_ld = 0;
  logic [4:0]  m_ldrt = '0;
  logic [31:0] m_ins = '0;
  logic [15:0] m_pc = '0;
  logic [15:0] m_prev_addr = '0;
  // 0 decode, 1 load-use stall, 2 jump, 3 halt detected, 4 already halted
  function automatic int act_of(input logic [31:0] i, input bit ld, input logic [4:0] rt, input bit h);
    logic [5:0] op;
    bit no_src, rt_src, haz;
    op = i[31:26];
    if (h) return 4;
    if (op == 6'd63) return 3;
    no_src = (op == 6'd2) || (op == 6'd3) || (i == 32'd0);
    rt_src = (op == 6'd0) || (op == 6'd43) || (op == 6'd4) || (op == 6'd5);
    haz = ld && rt != 5'd0 && !no_src && (i[25:21] == rt || (rt_src && i[20:16] == rt));
    if (haz) return 1;
    if (op == 6'd2 || op == 6'd3) return 2;
    return 0;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  always @(posedge clk) begin
    int a;
    if (!reset) begin
      m_init = 1; m_valid = 0; m_halted = 0; m_ld = 0; m_ldrt = '0;
      m_ins = '0; m_pc = '0; m_prev_addr = '0;
    end else if (m_init) begin
      a = act_of(ins, m_ld, m_ldrt, m_halted);
      if (a == 0 || a == 2) begin
        m_valid = 1; m_ins = ins; m_pc = m_prev_addr;
        m_ld = ins[31:26] == 6'd35; m_ldrt = ins[20:16];
      end else begin
        m_valid = 0; m_ld = 0;
        if (a == 3) m_halted = 1;
      end
      m_prev_addr = current_address;
    end
  end
  always @(negedge clk) begin
    int a;
    if (m_init) begin
      a = act_of(ins, m_ld, m_ldrt, m_halted);
      chk("stall", {31'd0, stall}, {31'd0, reset && a != 0 && a != 2});
      chk("stall_pm", {31'd0, stall_pm}, {31'd0, reset && m_halted});
      chk("pc_mux_sel", {31'd0, pc_mux_sel}, {31'd0, reset && a == 2});
      chk("jmp_loc", {16'd0, jmp_loc}, {16'd0, (reset && a == 2) ? ins[15:0] : 16'd0});
      chk("id_valid", {31'd0, id_valid}, {31'd0, m_valid});
      chk("halted", {31'd0, halted}, {31'd0, m_halted});
      chk("id_opcode", {26'd0, id_opcode}, {26'd0, m_ins[31:26]});
      chk("id_rs", {27'd0, id_rs}, {27'd0, m_ins[25:21]});
      chk("id_rt", {27'd0, id_rt}, {27'd0, m_ins[20:16]});
      chk("id_rd", {27'd0, id_rd}, {27'd0, m_ins[15:11]});
      chk("id_shamt", {27'd0, id_shamt}, {27'd0, m_ins[10:6]});
      chk("id_funct", {26'd0, id_funct}, {26'd0, m_ins[5:0]});
      chk("id_imm", id_imm, {{16{m_ins[15]}}, m_ins[15:0]});
      chk("id_pc", {16'd0, id_pc}, {16'd0, m_pc});
    end
  end
  task automatic step(input logic r, input logic [31:0] i, input logic [15:0] a);
    @(posedge clk);
    #2;
    reset = r; ins = i; current_address = a;
    @(negedge clk);
    #1;
  endtask
  initial begin
    repeat (3) step(1'b0, 32'hFFFFFFFF, 16'h0000);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_stall_pm", {31'd0, stall_pm}, 32'd0);
    chk("rst_pc_mux", {31'd0, pc_mux_sel}, 32'd0);
    chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_id_imm", id_imm, 32'd0);
    step(1'b1, 32'h00000000, 16'd5);
    step(1'b1, 32'h8C22FFFC, 16'd6);
    chk("lw_no_stall", {31'd0, stall}, 32'd0);
    step(1'b1, 32'h00441820, 16'd6);
    chk("lw_valid", {31'd0, id_valid}, 32'd1);
    chk("lw_opcode", {26'd0, id_opcode}, 32'h23);
    chk("lw_rs", {27'd0, id_rs}, 32'd1);
    chk("lw_rt", {27'd0, id_rt}, 32'd2);
    chk("lw_imm", id_imm, 32'hFFFFFFFC);
    chk("lw_pc", {16'd0, id_pc}, 32'd5);
    chk("use_stall", {31'd0, stall}, 32'd1);
    step(1'b1, 32'h00441820, 16'd7);
    chk("bubble_valid", {31'd0, id_valid}, 32'd0);
    chk("refetch_no_stall", {31'd0, stall}, 32'd0);
    step(1'b1, 32'h00000000, 16'd8);
    chk("add_valid", {31'd0, id_valid}, 32'd1);
    chk("add_rd", {27'd0, id_rd}, 32'd3);
    chk("add_pc", {16'd0, id_pc}, 32'd6);
    step(1'b1, 32'h8C000000, 16'd9);
    step(1'b1, 32'h00001820, 16'd10);
    chk("lw0_no_stall", {31'd0, stall}, 32'd0);
    step(1'b1, 32'h8CA50000, 16'd11);
    step(1'b1, 32'h20050001, 16'd12);
    chk("addi_rt_no_stall", {31'd0, stall}, 32'd0);
    step(1'b1, 32'h8C050000, 16'd13);
    step(1'b1, 32'h10050003, 16'd13);
    chk("beq_rt_stall", {31'd0, stall}, 32'd1);
    step(1'b1, 32'h10050003, 16'd14);
    step(1'b1, 32'h8C220000, 16'd15);
    step(1'b1, 32'h08000040, 16'h0040);
    chk("j_no_stall", {31'd0, stall}, 32'd0);
    chk("j_pc_mux", {31'd0, pc_mux_sel}, 32'd1);
    chk("j_loc", {16'd0, jmp_loc}, 32'h40);
    step(1'b1, 32'h00000000, 16'h0041);
    chk("j_valid", {31'd0, id_valid}, 32'd1);
    chk("j_opcode", {26'd0, id_opcode}, 32'd2);
    chk("j_loc_idle", {16'd0, jmp_loc}, 32'd0);
    step(1'b1, 32'h0C000020, 16'h0020);
    chk("jal_loc", {16'd0, jmp_loc}, 32'h20);
    chk("tgt_pc", {16'd0, id_pc}, 32'h40);
    step(1'b1, 32'hFC000000, 16'h0021);
    chk("halt_stall", {31'd0, stall}, 32'd1);
    chk("halt_pm_first", {31'd0, stall_pm}, 32'd0);
    chk("halt_not_yet", {31'd0, halted}, 32'd0);
    step(1'b1, 32'h00000000, 16'h0021);
    step(1'b1, 32'h08000040, 16'h0021);
    chk("halted", {31'd0, halted}, 32'd1);
    chk("halted_stall", {31'd0, stall}, 32'd1);
    chk("halted_pm", {31'd0, stall_pm}, 32'd1);
    chk("halted_valid", {31'd0, id_valid}, 32'd0);
    chk("halted_no_jump", {31'd0, pc_mux_sel}, 32'd0);
    step(1'b1, 32'h00441820, 16'h0021);
    step(1'b0, 32'h00000000, 16'h0000);
    chk("rst_forced_stall", {31'd0, stall}, 32'd0);
    chk("rst_forced_pm", {31'd0, stall_pm}, 32'd0);
    step(1'b1, 32'h00000000, 16'd1);
    chk("unhalt", {31'd0, halted}, 32'd0);
    chk("unhalt_stall", {31'd0, stall}, 32'd0);
    step(1'b1, 32'h00441820, 16'd2);
    chk("run_again_valid", {31'd0, id_valid}, 32'd1);
    step(1'b1, 32'h00000000, 16'd3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule

// File: doc/decode_hazard_block.md
Name: decode_hazard_block

Overview:
- Decode stage directly downstream of the program-memory/fetch block.
- Registers the fetched instruction into decoded fields for execute.
- Detects lw load-use hazards and requests a one-cycle refetch via stall.
- Resolves J/JAL by driving jmp_loc and pc_mux_sel back to fetch, and freezes fetch on HALT using stall and stall_pm.

Parameters:
- ADDR_W, 16, width of program addresses (current_address, jmp_loc, id_pc).
- INS_W, 32, instruction width.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset asserted).
- ins  in  INS_W  instruction from fetch; belongs to the address presented in the previous cycle.
- current_address  in  ADDR_W  address fetch presents to memory this cycle.
- stall  out  1  to fetch: reload the held address (refetch).
- stall_pm  out  1  to fetch: recirculate the previous instruction.
- pc_mux_sel  out  1  to fetch: select jmp_loc this cycle.
- jmp_loc  out  ADDR_W  jump target, ins[15:0].
- id_valid  out  1  decoded bundle valid (0 = bubble).
- id_opcode  out  6  ins[31:26].
- id_rs / id_rt / id_rd  out  5 each  ins[25:21] / ins[20:16] / ins[15:11].
- id_shamt  out  5  ins[10:6].
- id_funct  out  6  ins[5:0].
- id_imm  out  32  sign-extended ins[15:0].
- id_pc  out  ADDR_W  address of the decoded instruction.
- halted  out  1  HALT reached; sticky until reset.

Behaviour:
- Reset (reset==0 at posedge): all registered outputs 0, pc_q=0, ld_q=0, state=RUN.
- While reset==0, stall, stall_pm and pc_mux_sel are forced 0 combinationally.
- pc_q captures current_address every cycle. ins in cycle t therefore has address pc_q.
- Load tracking: ld_q / ld_rt_q record whether the last valid registered bundle was an lw (opcode 100011) and its rt.
- uses_rt: asserted for opcode 000000, 101011 (sw), 000100 (beq) and 000101 (bne).
- Sources: J (000010), JAL (000011), HALT (111111) and all-zero ins have no sources.
- Hazard is true when ld_q, ld_rt_q!=0, the instruction has sources, and (ld_rt_q==rs OR (uses_rt AND ld_rt_q==rt)).
- FSM states: RUN, HALT.
- RUN, priority order (one action per cycle):
  1. Opcode 111111: stall=1 this cycle. Next cycle: state=HALT, bubble.
  2. Hazard: stall=1 this cycle. Register a bubble (id_valid=0, ld_q=0); fetch re-presents the same address, so the instruction reappears next cycle and is not re-flagged.
  3. J/JAL: pc_mux_sel=1 and jmp_loc=ins[15:0] combinationally this cycle. Register the bundle with id_valid=1 (JAL link = id_pc+1 is computed downstream). There is no delay slot; the target instruction arrives next cycle.
  4. Otherwise: register all fields, id_valid=1, id_pc=pc_q.
- Decode latency: 1 cycle (ins in cycle t gives id_* valid after posedge t).
- HALT: stall=1 and stall_pm=1 every cycle (stall_pm is registered, never asserted in the detection cycle), id_valid=0, halted=1. The only exit is reset.
- Bubble: id_valid=0; other id_* fields hold their previous values.
- all-zero ins (sll $0): decoded as a valid NOP.
- Outside HALT, stall_pm is always 0. jmp_loc is 0 when pc_mux_sel=0.
- Reset mid-stall or mid-HALT: the next cycle with reset==1 starts in RUN with no pending hazard.

Decomposition:
- Shared package mips_defs_pkg: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_HALT), field bit positions, FSM state encoding.
- One sub-module, hazard_detect: purely combinational load-use comparator (inputs ld_q, ld_rt_q, ins; output hazard).

Test Plan:
- Reset: hold reset=0 for 3 cycles with ins=32'hFFFFFFFF -> all outputs 0, stall=stall_pm=pc_mux_sel=0.
- Plain decode: ins=32'h8C22FFFC (lw $2,-4($1)) at pc_q=5 -> next cycle id_valid=1, id_opcode=6'h23, rs=1, rt=2, id_imm=32'hFFFFFFFC, id_pc=5.
- Load-use: lw $2 followed by add $3,$2,$4 (32'h00441820) -> stall=1 in the add cycle; id_valid=0 next cycle; add decoded once, one cycle later, no second stall.
- No false hazard: lw $0 then add reading $0 -> stall=0. lw $2 then j 0x0040 -> stall=0.
- Jump: ins=32'h08000040 -> same cycle pc_mux_sel=1, jmp_loc=16'h0040; next cycle id_valid=1, id_opcode=2; the following id_pc=16'h0040.
- Halt: ins=32'hFC000000 -> stall=1 that cycle; then halted=1, stall=stall_pm=1, id_valid=0 indefinitely. Pulsing reset=0 for one cycle returns to RUN with halted=0.
